// File: rtl/vga_pkg.sv
// Shared constants, state encoding and cell-word layout for the VGA text-RAM write arbiter.
package vga_pkg;

  localparam int unsigned TEXT_COLS    = 80;
  localparam int unsigned TEXT_ROWS    = 30;
  localparam int unsigned SCREEN_CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 16;

  // Cell word is {attr[7:0], char[7:0]}
  localparam int unsigned ATTR_LSB   = 8;
  localparam int unsigned CHAR_LSB   = 0;
  localparam logic [15:0] BLANK_CELL = 16'h0000;

  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } cell_t;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Requester/clear/text-RAM signal bundle between game FSMs and the write arbiter.
interface vga_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = vga_pkg::ADDR_W,
  parameter int unsigned DATA_W  = vga_pkg::DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_start;
  logic [DATA_W-1:0]         clear_data;
  logic                      clear_busy;
  logic                      clear_done;
  logic                      addr_err;
  logic [ADDR_W-1:0]         vga_addr;
  logic                      vga_we;
  logic [DATA_W-1:0]         vga_data;

  modport master (
    output req_valid, req_addr, req_data, clear_start, clear_data,
    input  req_ready, clear_busy, clear_done, addr_err, vga_addr, vga_we, vga_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_start, clear_data,
    output req_ready, clear_busy, clear_done, addr_err, vga_addr, vga_we, vga_data
  );

endinterface

// File: rtl/vga_write_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first valid requester at or above ptr_i, wrapping around.
module vga_write_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic found;

  // Outer loop walks priority order from ptr_i; inner loop maps that slot to a requester.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!found && valid_i[j] &&
            (32'(j) == (32'(ptr_i) + 32'(i)) % NUM_REQ)) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = PTR_W'(j);
        end
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the text-RAM write port between NUM_REQ requesters (round-robin) and a full-screen clear engine.
module vga_write_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_W       = vga_pkg::ADDR_W,
  parameter int unsigned DATA_W       = vga_pkg::DATA_W,
  parameter int unsigned SCREEN_CELLS = vga_pkg::SCREEN_CELLS
) (
  input  logic                clk,
  input  logic                rst,
  vga_write_arbiter_if.slave  bus
);

  import vga_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   fill_q;
  logic [ADDR_W-1:0]   vga_addr_q;
  logic [DATA_W-1:0]   vga_data_q;
  logic                vga_we_q;
  logic                clear_done_q;
  logic                addr_err_q;

  logic [NUM_REQ-1:0]  grant_c;
  logic [PTR_W-1:0]    gnt_idx_c;
  logic                gnt_any_c;
  logic                arb_open_c;
  logic                xfer_c;
  logic                in_range_c;
  logic                last_cell_c;
  logic [PTR_W-1:0]    rr_ptr_d;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_data_c;

  vga_write_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_c),
    .idx_o   (gnt_idx_c),
    .any_o   (gnt_any_c)
  );

  // Grants are withheld in reset, in CLEAR, and in the cycle a clear is accepted.
  assign arb_open_c    = !rst && (state_q == ST_ARB) && !bus.clear_start;
  assign bus.req_ready = arb_open_c ? grant_c : '0;
  assign xfer_c        = arb_open_c && gnt_any_c;

  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (PTR_W'(i) == gnt_idx_c) begin
        sel_addr_c = bus.req_addr[i*int'(ADDR_W) +: ADDR_W];
        sel_data_c = bus.req_data[i*int'(DATA_W) +: DATA_W];
      end
    end
  end

  assign in_range_c  = 32'(sel_addr_c) < SCREEN_CELLS;
  assign last_cell_c = cnt_q == ADDR_W'(SCREEN_CELLS - 1);
  assign rr_ptr_d    = (gnt_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      vga_addr_q   <= '0;
      vga_data_q   <= '0;
      vga_we_q     <= 1'b0;
      clear_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      vga_we_q     <= 1'b0;
      clear_done_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (bus.clear_start) begin
            state_q <= ST_CLEAR;
            fill_q  <= bus.clear_data;
            cnt_q   <= '0;
          end else if (xfer_c) begin
            rr_ptr_q <= rr_ptr_d;
            if (in_range_c) begin
              vga_we_q   <= 1'b1;
              vga_addr_q <= sel_addr_c;
              vga_data_q <= sel_data_c;
            end else begin
              addr_err_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          vga_we_q   <= 1'b1;
          vga_addr_q <= cnt_q;
          vga_data_q <= fill_q;
          // Counter parks on the last cell; done rides along with that final write.
          if (last_cell_c) begin
            clear_done_q <= 1'b1;
            state_q      <= ST_ARB;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign bus.clear_done = clear_done_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.vga_addr   = vga_addr_q;
  assign bus.vga_we     = vga_we_q;
  assign bus.vga_data   = vga_data_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed scoreboard bench for vga_write_arbiter: round-robin, clear engine, range errors, async reset.
module tb_vga_write_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned CELLS = 2400;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic clk;
  logic rst;

  vga_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SCREEN_CELLS(CELLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  exp_t sb_q[$];

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  logic [1:0]    exp_ptr;
  int            gcnt [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_req();
    for (int i = 0; i < int'(N); i++) begin
      bus.req_addr[i*int'(AW) +: AW] = addr_a[i];
      bus.req_data[i*int'(DW) +: DW] = data_a[i];
    end
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic [1:0] p);
    logic [N-1:0] g;
    g = '0;
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (int'(p) + i) % int'(N);
      if (g == '0 && v[k]) g[k] = 1'b1;
    end
    return g;
  endfunction

  // One ARB cycle: check grant against the model, record the expected write, advance.
  task automatic req_cycle(input logic [N-1:0] v, input string tag);
    logic [N-1:0] g;
    bus.req_valid = v;
    pack_req();
    #1;
    g = model_grant(v, exp_ptr);
    chk(tag, 32'(bus.req_ready), 32'(g));
    for (int k = 0; k < int'(N); k++) begin
      if (g[k]) begin
        gcnt[k]++;
        if (32'(addr_a[k]) < CELLS) sb_q.push_back('{addr: addr_a[k], data: data_a[k], done: 1'b0});
        exp_ptr = 2'((k + 1) % int'(N));
      end
    end
    tick();
  endtask

  // Scoreboard monitor: every write must match the next expected entry, in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.clear_done) done_cnt++;
      if (bus.vga_we) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write", 32'(bus.vga_addr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("wr_addr", 32'(bus.vga_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.vga_data), 32'(e.data));
          chk("wr_done", 32'(bus.clear_done), 32'(e.done));
        end
      end else begin
        chk("done_without_we", 32'(bus.clear_done), 32'h0);
      end
    end
  end

  initial begin
    int cycles;
    int done_before;
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.clear_start = 1'b0;
    bus.clear_data  = '0;
    exp_ptr         = 2'd0;
    for (int i = 0; i < int'(N); i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
      gcnt[i]   = 0;
    end

    #12;
    chk("rst_ready",  32'(bus.req_ready),  32'h0);
    chk("rst_we",     32'(bus.vga_we),     32'h0);
    chk("rst_busy",   32'(bus.clear_busy), 32'h0);
    chk("rst_done",   32'(bus.clear_done), 32'h0);
    chk("rst_err",    32'(bus.addr_err),   32'h0);
    chk("rst_addr",   32'(bus.vga_addr),   32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Single requester, then pointer check via 3-vs-0 contention.
    addr_a[2] = 12'd840; data_a[2] = 16'h0e13;
    req_cycle(4'b0100, "single_req2");
    bus.req_valid = '0;
    #1;
    chk("single_we",   32'(bus.vga_we),   32'h1);
    chk("single_addr", 32'(bus.vga_addr), 32'd840);
    chk("single_data", 32'(bus.vga_data), 32'h0e13);
    addr_a[0] = 12'd1;   data_a[0] = 16'h1111;
    addr_a[3] = 12'd3;   data_a[3] = 16'h3333;
    req_cycle(4'b1001, "ptr3_grant");
    req_cycle(4'b1001, "wrap_grant0");
    req_cycle(4'b1000, "align_ptr0");

    // Fairness: all requesters continuously valid.
    for (int i = 0; i < int'(N); i++) begin
      addr_a[i] = AW'(100 * i + 7);
      data_a[i] = DW'(16'hA000 + i);
      gcnt[i]   = 0;
    end
    for (int c = 0; c < 16; c++) begin
      req_cycle(4'b1111, "fair_grant");
      chk("fair_we", 32'(bus.vga_we), 32'h1);
    end
    for (int i = 0; i < int'(N); i++) chk("fair_count", 32'(gcnt[i]), 32'd4);
    bus.req_valid = '0;

    // Out-of-range address is accepted then dropped; error is sticky.
    addr_a[0] = 12'd2400; data_a[0] = 16'hdead;
    req_cycle(4'b0001, "oor_grant");
    bus.req_valid = '0;
    #1;
    chk("oor_we",  32'(bus.vga_we),   32'h0);
    chk("oor_err", 32'(bus.addr_err), 32'h1);
    addr_a[1] = 12'd2399; data_a[1] = 16'h1234;
    req_cycle(4'b0010, "edge_grant");
    bus.req_valid = '0;
    #1;
    chk("edge_we",  32'(bus.vga_we),   32'h1);
    chk("err_keep", 32'(bus.addr_err), 32'h1);
    tick();

    // Clear with a simultaneous request from requester 1.
    addr_a[1] = 12'd5; data_a[1] = 16'h5555;
    pack_req();
    bus.req_valid   = 4'b0010;
    bus.clear_start = 1'b1;
    bus.clear_data  = 16'h0020;
    #1;
    chk("clr_start_ready", 32'(bus.req_ready), 32'h0);
    for (int k = 0; k < int'(CELLS); k++)
      sb_q.push_back('{addr: AW'(k), data: 16'h0020, done: (k == int'(CELLS) - 1)});
    done_before = done_cnt;
    tick();
    bus.clear_start = 1'b0;
    cycles = 0;
    while (bus.clear_busy && cycles < 3000) begin
      chk("clr_ready", 32'(bus.req_ready), 32'h0);
      if (cycles == 100) begin
        bus.clear_start = 1'b1;
        bus.clear_data  = 16'hffff;
      end else begin
        bus.clear_start = 1'b0;
      end
      cycles++;
      tick();
    end
    bus.clear_start = 1'b0;
    chk("clr_busy_cycles", 32'(cycles), CELLS);
    chk("clr_done_now",    32'(bus.clear_done), 32'h1);
    req_cycle(4'b0010, "post_clear_grant");
    bus.req_valid = '0;
    tick();
    chk("clr_done_once", 32'(done_cnt - done_before), 32'd1);
    chk("sb_drained",    32'(sb_q.size()), 32'd0);

    // Async reset in the middle of a clear.
    bus.clear_start = 1'b1;
    bus.clear_data  = 16'h0707;
    #1;
    for (int k = 0; k < 999; k++) sb_q.push_back('{addr: AW'(k), data: 16'h0707, done: 1'b0});
    done_before = done_cnt;
    tick();
    bus.clear_start = 1'b0;
    addr_a[2] = 12'd77; data_a[2] = 16'h7777;
    pack_req();
    bus.req_valid = 4'b0100;
    repeat (1000) tick();
    chk("pre_rst_busy", 32'(bus.clear_busy), 32'h1);
    chk("pre_rst_addr", 32'(bus.vga_addr),   32'd999);
    rst = 1'b1;
    #1;
    chk("arst_we",    32'(bus.vga_we),     32'h0);
    chk("arst_busy",  32'(bus.clear_busy), 32'h0);
    chk("arst_ready", 32'(bus.req_ready),  32'h0);
    chk("arst_done",  32'(bus.clear_done), 32'h0);
    chk("arst_err",   32'(bus.addr_err),   32'h0);
    repeat (3) tick();
    chk("arst_sb",        32'(sb_q.size()), 32'd0);
    sb_q.delete();
    chk("arst_no_done",   32'(done_cnt - done_before), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ptr = 2'd0;
    for (int i = 0; i < int'(N); i++) begin
      addr_a[i] = AW'(200 + i);
      data_a[i] = DW'(16'hB000 + i);
    end
    req_cycle(4'b1111, "post_rst_grant0");
    req_cycle(4'b1111, "post_rst_grant1");
    bus.req_valid = '0;
    tick();
    tick();
    chk("final_sb", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
